// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and channel encoding for the I2S transmitter
package i2s_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_sclk_gen.sv
// i2s_sclk_gen: divides mclk rising edges into sclk, realigned to 0 on every lrck edge
module i2s_sclk_gen #(
  parameter int SCLK_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mclk_rise,
  input  logic lrck_edge,
  output logic sclk,
  output logic sclk_fall
);
  localparam int W = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = mclk_rise && (cnt == W'(SCLK_HALF - 1));
  // a forced realignment to 0 is a frame reload, not a shift slot
  assign sclk_fall = wrap && sclk && !lrck_edge;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (lrck_edge) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sclk <= ~sclk;
    end else if (mclk_rise) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S serialiser with a one-pair input buffer and underrun tracking
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SCLK_HALF = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mclk,
  input  logic              lrck,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              sclk,
  output logic              lrck_out,
  output logic              sdata,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  localparam int BW = $clog2(DATA_W + 1);
  logic mclk_q, lrck_q, full, sclk_fall, more;
  logic mclk_rise, lrck_fall, lrck_rise, lrck_edge, accept;
  logic [DATA_W-1:0] buf_l, buf_r, shifter, right_stage;
  logic [BW-1:0] bit_cnt;
  assign mclk_rise = mclk & ~mclk_q;
  assign lrck_fall = (lrck == CH_LEFT) && (lrck_q == CH_RIGHT);
  assign lrck_rise = (lrck == CH_RIGHT) && (lrck_q == CH_LEFT);
  assign lrck_edge = lrck_fall | lrck_rise;
  assign in_ready = ~full;
  assign accept = in_valid & in_ready;
  assign lrck_out = lrck_q;
  assign more = bit_cnt < BW'(DATA_W);
  i2s_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .clk(clk),
    .rst(rst),
    .mclk_rise(mclk_rise),
    .lrck_edge(lrck_edge),
    .sclk(sclk),
    .sclk_fall(sclk_fall)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mclk_q <= 1'b0;
      lrck_q <= 1'b0;
      full <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
      shifter <= '0;
      right_stage <= '0;
      bit_cnt <= '0;
      sdata <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      mclk_q <= mclk;
      lrck_q <= lrck;
      if (accept) begin
        buf_l <= in_left;
        buf_r <= in_right;
      end
      // an accept on an empty frame start refills the buffer for the next frame
      full <= accept | (full & ~lrck_fall);
      underrun <= lrck_fall & ~full;
      if (lrck_fall & ~full & ~&underrun_cnt) underrun_cnt <= underrun_cnt + 1'b1;
      if (lrck_fall) begin
        shifter <= full ? buf_l : '0;
        right_stage <= full ? buf_r : '0;
      end else if (lrck_rise) begin
        shifter <= right_stage;
      end else if (sclk_fall && more) begin
        shifter <= {shifter[DATA_W-2:0], 1'b0};
      end
      if (lrck_edge) begin
        bit_cnt <= '0;
        sdata <= 1'b0;
      end else if (sclk_fall) begin
        sdata <= more & shifter[DATA_W-1];
        bit_cnt <= bit_cnt + BW'(more);
      end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed, table-driven checks of the I2S transmitter
module tb_i2s_tx;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [15:0] in_left = '0, in_right = '0;
  logic mclk, lrck, in_ready, sclk, lrck_out, sdata, underrun;
  logic [15:0] underrun_cnt;
  int k = 0;
  int errors = 0, checks = 0;
  int ur_high = 0, ur_rise = 0;
  logic ur_prev = 0;
  typedef struct {
    logic [15:0] l, r;
    logic [31:0] el, er;
  } vec_t;
  vec_t v[8];
  assign mclk = k[2];
  assign lrck = k[9];
  i2s_tx #(.DATA_W(16), .SCLK_HALF(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mclk(mclk), .lrck(lrck),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .sclk(sclk), .lrck_out(lrck_out), .sdata(sdata),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  initial forever @(negedge clk) k++;
  initial forever @(negedge clk) begin
    if (underrun) ur_high++;
    if (underrun && !ur_prev) ur_rise++;
    ur_prev = underrun;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    do @(posedge clk); while (k[9]);
    @(negedge clk);
    rst = 1;
  endtask
  task automatic wait_lr(input logic val);
    int t = 0;
    while (lrck_out == val && t < 3000) begin @(negedge clk); t++; end
    while (lrck_out != val && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) tmo("lrck_wait");
  endtask
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    @(negedge clk);
    in_valid = 1;
    in_left = l;
    in_right = r;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) tmo("send");
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic capture_half(output logic [31:0] bits, output int n);
    logic start, ps;
    int t = 0;
    start = lrck_out;
    ps = sclk;
    bits = '0;
    n = 0;
    while (t < 3000) begin
      @(negedge clk);
      t++;
      if (lrck_out != start) break;
      if (sclk && !ps) begin
        bits = {bits[30:0], sdata};
        n++;
      end
      ps = sclk;
    end
    if (t >= 3000) tmo("capture");
  endtask
  task automatic check_half(input string nm, input logic [31:0] exp);
    logic [31:0] b;
    int n;
    capture_half(b, n);
    chk({nm, "_bits"}, b, exp);
    chk({nm, "_len"}, n, 32);
  endtask
  initial begin
    v[0] = '{16'hA55A, 16'h8001, 32'h52AD0000, 32'h40008000};
    v[1] = '{16'h0001, 16'hC001, 32'h00008000, 32'h60008000};
    v[2] = '{16'h0002, 16'hC002, 32'h00010000, 32'h60010000};
    v[3] = '{16'h0003, 16'hC003, 32'h00018000, 32'h60018000};
    v[4] = '{16'h0004, 16'hC004, 32'h00020000, 32'h60020000};
    v[5] = '{16'h1357, 16'hFEDC, 32'h09AB8000, 32'h7F6E0000};
    v[6] = '{16'h1234, 16'h5678, 32'h091A0000, 32'h2B3C0000};
    v[7] = '{16'h0F0F, 16'hF0F0, 32'h07878000, 32'h78780000};
    #1 rst = 0;
    repeat (10) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_lrck_out", lrck_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);
    // single frame
    do_reset();
    wait_lr(1);
    send(v[0].l, v[0].r);
    chk("single_ready_full", in_ready, 0);
    wait_lr(0);
    chk("single_ready_after_fall", in_ready, 1);
    check_half("single_left", v[0].el);
    check_half("single_right", v[0].er);
    // back-pressure across four frames
    do_reset();
    wait_lr(1);
    send(v[1].l, v[1].r);
    chk("bp_ready_full", in_ready, 0);
    fork
      begin
        for (int i = 2; i <= 4; i++) begin
          send(v[i].l, v[i].r);
          chk("bp_accept_in_left_half", lrck_out, 0);
        end
      end
      begin
        wait_lr(0);
        for (int i = 1; i <= 4; i++) begin
          check_half($sformatf("bp%0d_left", i), v[i].el);
          check_half($sformatf("bp%0d_right", i), v[i].er);
        end
      end
    join
    // three underrun frames
    do_reset();
    wait_lr(1);
    ur_high = 0;
    ur_rise = 0;
    wait_lr(0);
    for (int i = 0; i < 5; i++) check_half($sformatf("ur_half%0d", i), 32'h0);
    chk("ur_pulses", ur_rise, 3);
    chk("ur_high_cycles", ur_high, 3);
    chk("ur_cnt", underrun_cnt, 3);
    // accept coinciding with a frame start on an empty buffer
    do_reset();
    do @(posedge clk); while (k[9:0] != 10'h3FF);
    #1;
    in_valid = 1;
    in_left = v[5].l;
    in_right = v[5].r;
    chk("coinc_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("coinc_underrun", underrun, 1);
    chk("coinc_ready_full", in_ready, 0);
    chk("coinc_cnt", underrun_cnt, 1);
    check_half("coinc_zero_left", 32'h0);
    check_half("coinc_zero_right", 32'h0);
    check_half("coinc_left", v[5].el);
    check_half("coinc_right", v[5].er);
    // reset in the middle of a left half-frame
    do_reset();
    wait_lr(1);
    send(v[6].l, v[6].r);
    wait_lr(0);
    send(16'hDEAD, 16'hBEEF);
    begin
      logic ps;
      int n = 0, t = 0;
      ps = sclk;
      while (n < 6 && t < 3000) begin
        @(negedge clk);
        t++;
        if (sclk && !ps) n++;
        ps = sclk;
      end
      if (t >= 3000) tmo("mid_bits");
    end
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("mid_sclk", sclk, 0);
    chk("mid_sdata", sdata, 0);
    chk("mid_lrck_out", lrck_out, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_underrun_cnt", underrun_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    send(v[7].l, v[7].r);
    wait_lr(1);
    check_half("mid_first_right", 32'h0);
    check_half("mid_left", v[7].el);
    check_half("mid_right", v[7].er);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
